// File: rtl/itype_pkg.sv
// itype_pkg: opcodes, controller states, error codes and immediate-extension helpers
// shared by the I-type execution sequencer.
package itype_pkg;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE} state_t;
  typedef enum logic [1:0] {ERR_OK, ERR_ILL, ERR_OVF, ERR_MEM} err_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_SLTI, OP_SLTIU,
                      OP_BEQ, OP_BNE, OP_LW, OP_SW};
  endfunction
  // Logical immediates are zero-extended; everything else is sign-extended.
  function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
    return (op inside {OP_ANDI, OP_ORI, OP_LUI}) ? {16'h0, imm} : {{16{imm[15]}}, imm};
  endfunction
endpackage

// File: rtl/itype_regfile.sv
// itype_regfile: 32x32 register file, two async read ports plus a debug read port,
// one synchronous write port; register 0 is never written so it always reads 0.
module itype_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_ra,
  input  logic [4:0]  i_rb,
  input  logic [4:0]  i_dbg_addr,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ra_data,
  output logic [31:0] o_rb_data,
  output logic [31:0] o_dbg_data
);
  logic [31:0] r_regs [32];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    else if (i_we && i_waddr != 5'd0)
      r_regs[i_waddr] <= i_wdata;
  assign o_ra_data  = r_regs[i_ra];
  assign o_rb_data  = r_regs[i_rb];
  assign o_dbg_data = r_regs[i_dbg_addr];
endmodule

// File: rtl/itype_exec_ctrl.sv
// itype_exec_ctrl: multi-cycle I-type sequencer driving an external combinational ALU.
// Define ITYPE_OVF_TRAP_EN to make ADDI overflow suppress writeback and report err=2.
module itype_exec_ctrl
  import itype_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [31:0] alu_imm,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        done,
  output logic        branch_taken,
  output logic [1:0]  err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  state_t      r_state, w_next;
  err_t        r_err;
  logic [31:0] r_instr, r_rs_val, r_rt_val, r_imm, r_result, r_pc, r_wait;
  logic        r_zero, r_ovf, r_taken;
  logic [31:0] w_rs_data, w_rt_data;
  logic [5:0]  w_op;
  logic        w_branch, w_timeout, w_trap, w_we;
  assign w_op      = r_instr[31:26];
  assign w_branch  = w_op == OP_BEQ || w_op == OP_BNE;
  assign w_timeout = r_wait == MEM_TIMEOUT - 1;
`ifdef ITYPE_OVF_TRAP_EN
  assign w_trap = w_op == OP_ADDI && r_ovf;
`else
  assign w_trap = 1'b0 && r_ovf;
`endif
  assign w_we = r_state == S_WB && !w_branch && !w_trap;
  itype_regfile u_rf (
    .clk       (clk),
    .reset     (reset),
    .i_ra      (r_instr[25:21]),
    .i_rb      (r_instr[20:16]),
    .i_dbg_addr(dbg_addr),
    .i_we      (w_we),
    .i_waddr   (r_instr[20:16]),
    .i_wdata   (r_result),
    .o_ra_data (w_rs_data),
    .o_rb_data (w_rt_data),
    .o_dbg_data(dbg_data)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = instr_valid ? S_DECODE : S_IDLE;
      S_DECODE: w_next = is_legal(w_op) ? S_EXEC : S_DONE;
      S_EXEC:   w_next = (w_op == OP_LW || w_op == OP_SW) ? S_MEM : S_WB;
      S_MEM:    w_next = mem_ack ? (w_op == OP_SW ? S_DONE : S_WB) : (w_timeout ? S_DONE : S_MEM);
      S_WB:     w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state  <= S_IDLE;
      r_err    <= ERR_OK;
      r_instr  <= 32'h0;
      r_rs_val <= 32'h0;
      r_rt_val <= 32'h0;
      r_imm    <= 32'h0;
      r_result <= 32'h0;
      r_pc     <= PC_RESET;
      r_wait   <= 32'h0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_taken  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (instr_valid) begin
          r_instr <= instr;
          r_err   <= ERR_OK;
          r_taken <= 1'b0;
        end
        S_DECODE: begin
          r_rs_val <= w_rs_data;
          r_rt_val <= w_rt_data;
          r_imm    <= ext_imm(w_op, r_instr[15:0]);
          if (!is_legal(w_op)) r_err <= ERR_ILL;
        end
        S_EXEC: begin
          r_result <= alu_result;
          r_zero   <= alu_zero;
          r_ovf    <= alu_overflow;
          r_wait   <= 32'h0;
        end
        // Load data reuses the result register since the address is no longer needed.
        S_MEM: begin
          r_wait <= r_wait + 32'd1;
          if (mem_ack) r_result <= mem_rdata;
          else if (w_timeout) r_err <= ERR_MEM;
        end
        S_WB: begin
          r_taken <= w_branch && (w_op == OP_BEQ ? r_zero : !r_zero);
          if (w_trap) r_err <= ERR_OVF;
        end
        S_DONE: r_pc <= r_pc + 32'd4 + (r_taken ? {r_imm[29:0], 2'b00} : 32'd0);
        default: ;
      endcase
    end
  assign instr_ready  = r_state == S_IDLE;
  assign alu_opcode   = w_op;
  assign alu_rs       = r_rs_val;
  assign alu_rt       = r_rt_val;
  assign alu_imm      = r_imm;
  assign mem_req      = r_state == S_MEM;
  assign mem_we       = mem_req && w_op == OP_SW;
  assign mem_addr     = r_result;
  assign mem_wdata    = r_rt_val;
  assign pc           = r_pc;
  assign done         = r_state == S_DONE;
  assign branch_taken = done && r_taken;
  assign err          = done ? r_err : ERR_OK;
endmodule

// File: tb/tb_itype_exec_ctrl.sv
// tb_itype_exec_ctrl: directed self-checking bench with a behavioural ALU and a
// memory responder whose ack delay is set per instruction.
module tb_itype_exec_ctrl;
  import itype_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, instr_ready;
  logic [31:0] instr = 32'h0;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_rs, alu_rt, alu_imm, alu_result;
  logic        alu_zero, alu_overflow;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0, pc, dbg_data;
  logic        done, branch_taken;
  logic [1:0]  err;
  logic [4:0]  dbg_addr = 5'd0;
  int          n_checks = 0, n_errors = 0;
  logic        m_we, m_req_done;
  logic [31:0] m_addr, m_wd;

  itype_exec_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_imm(alu_imm), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pc(pc), .done(done), .branch_taken(branch_taken),
    .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'h0;
    case (alu_opcode)
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_result = alu_rs + alu_imm;
      OP_ANDI:  alu_result = alu_rs & alu_imm;
      OP_ORI:   alu_result = alu_rs | alu_imm;
      OP_LUI:   alu_result = {alu_imm[15:0], 16'h0};
      OP_SLTI:  alu_result = {31'h0, $signed(alu_rs) < $signed(alu_imm)};
      OP_SLTIU: alu_result = {31'h0, alu_rs < alu_imm};
      OP_BEQ, OP_BNE: alu_result = alu_rs - alu_rt;
      default: ;
    endcase
    alu_zero     = alu_result == 32'h0;
    alu_overflow = alu_opcode == OP_ADDI && alu_rs[31] == alu_imm[31] && alu_result[31] != alu_rs[31];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Issues one instruction, acks the memory on the ack_at-th MEM cycle (-1 = never),
  // then checks latency, branch/err at done and pc in the following cycle.
  task automatic op(input string tag, input logic [31:0] ins, input int ack_at,
                    input logic [31:0] rd, input int exp_lat, input logic exp_tk,
                    input logic [1:0] exp_err, input logic [31:0] exp_pc);
    int mc = 0, lat = -1, w = 0;
    logic tk = 1'b0;
    logic [1:0] er = 2'd0;
    while (!instr_ready && w < 50) begin @(posedge clk); #1; w++; end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (mc == ack_at) begin
          mem_ack = 1'b1; mem_rdata = rd;
          m_we = mem_we; m_addr = mem_addr; m_wd = mem_wdata;
        end
        mc++;
      end
      if (done) begin
        lat = c; tk = branch_taken; er = err; m_req_done = mem_req;
        break;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " branch_taken"}, {31'h0, tk}, {31'h0, exp_tk});
    check({tag, " err"}, {30'h0, er}, {30'h0, exp_err});
    @(posedge clk); #1;
    check({tag, " pc"}, pc, exp_pc);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst instr_ready", {31'h0, instr_ready}, 32'd1);
    check("rst done", {31'h0, done}, 32'd0);
    check("rst mem_req", {31'h0, mem_req}, 32'd0);
    check("rst pc", pc, 32'h0);
    check("rst err", {30'h0, err}, 32'd0);
    check("rst branch_taken", {31'h0, branch_taken}, 32'd0);
    reset = 1'b0;
    check("rst ready after release", {31'h0, instr_ready}, 32'd1);

    op("addi r1", {OP_ADDI, 5'd0, 5'd1, 16'hB4E9}, -1, 0, 4, 0, 0, 32'd4);
    check_reg("r1", 5'd1, 32'hFFFF_B4E9);
    op("ori r2", {OP_ORI, 5'd0, 5'd2, 16'h2A19}, -1, 0, 4, 0, 0, 32'd8);
    check_reg("r2", 5'd2, 32'h0000_2A19);
    op("slti r8", {OP_SLTI, 5'd1, 5'd8, 16'h0000}, -1, 0, 4, 0, 0, 32'd12);
    check_reg("r8", 5'd8, 32'd1);
    op("beq taken", {OP_BEQ, 5'd2, 5'd2, 16'd3}, -1, 0, 4, 1, 0, 32'd28);

    op("sw", {OP_SW, 5'd0, 5'd2, 16'd8}, 2, 0, 6, 0, 0, 32'd32);
    check("sw mem_we", {31'h0, m_we}, 32'd1);
    check("sw mem_addr", m_addr, 32'd8);
    check("sw mem_wdata", m_wd, 32'h2A19);
    op("lw", {OP_LW, 5'd0, 5'd3, 16'd8}, 2, 32'hDEAD_BEEF, 7, 0, 0, 32'd36);
    check("lw mem_we", {31'h0, m_we}, 32'd0);
    check("lw mem_addr", m_addr, 32'd8);
    check_reg("r3", 5'd3, 32'hDEAD_BEEF);

    op("lui r5", {OP_LUI, 5'd0, 5'd5, 16'h7FFF}, -1, 0, 4, 0, 0, 32'd40);
    op("ori r5", {OP_ORI, 5'd5, 5'd5, 16'hFFFF}, -1, 0, 4, 0, 0, 32'd44);
    check_reg("r5", 5'd5, 32'h7FFF_FFFF);
`ifdef ITYPE_OVF_TRAP_EN
    op("addi ovf", {OP_ADDI, 5'd5, 5'd4, 16'd1}, -1, 0, 4, 0, 2'd2, 32'd48);
    check_reg("r4 trap", 5'd4, 32'h0);
`else
    op("addi ovf", {OP_ADDI, 5'd5, 5'd4, 16'd1}, -1, 0, 4, 0, 2'd0, 32'd48);
    check_reg("r4 wrap", 5'd4, 32'h8000_0000);
`endif
    op("addiu r0", {OP_ADDIU, 5'd5, 5'd0, 16'd1}, -1, 0, 4, 0, 0, 32'd52);
    check_reg("r0", 5'd0, 32'h0);
    op("illegal", {6'b111111, 5'd0, 5'd6, 16'h1234}, -1, 0, 2, 0, 2'd1, 32'd56);
    check_reg("r6 illegal", 5'd6, 32'h0);
    op("bne back", {OP_BNE, 5'd1, 5'd2, 16'hFFFE}, -1, 0, 4, 1, 0, 32'd52);
    op("beq not", {OP_BEQ, 5'd1, 5'd2, 16'd5}, -1, 0, 4, 0, 0, 32'd56);
    op("lw timeout", {OP_LW, 5'd0, 5'd6, 16'h10}, -1, 0, 19, 0, 2'd3, 32'd60);
    check("timeout mem_req", {31'h0, m_req_done}, 32'd0);
    check_reg("r6 timeout", 5'd6, 32'h0);

    instr = {OP_LW, 5'd0, 5'd7, 16'h20};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int c = 0; c < 10 && !mem_req; c++) begin @(posedge clk); #1; end
    check("mid reach mem", {31'h0, mem_req}, 32'd1);
    reset = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    check("mid mem_req", {31'h0, mem_req}, 32'd0);
    check("mid pc", pc, 32'h0);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("mid ready", {31'h0, instr_ready}, 32'd1);
    check_reg("mid r7", 5'd7, 32'h0);
    check_reg("mid r3 cleared", 5'd3, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
